// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Initiator side of the ALU interface. Accepts an opcode (or a PC-increment
//   request) with two operands, loads the Y operand register, drives a one-hot
//   ALU control word for the EXEC phase, captures {alu_chigh, alu_clow} into
//   the 64-bit Z register and raises the HI/LO or Rz write enable on WRITE.
//   One operation in flight; requests seen while busy are dropped.
//
//   Optional build macro: ALU_SEQ_SHAMT_MASK_EN
//     When defined, shift/rotate ops present only B[4:0] on alu_b.
//
//   Request semantics: start and inc_pc are single-cycle level requests that
//   are sampled only while the FSM is in IDLE; there is no ready/ack, a request
//   presented while busy is simply not taken. start has priority over inc_pc.
//
//   dbg_state exposes the FSM state encoding for checkers.

module alu_op_sequencer #(
  parameter int MULDIV_WAIT = 2,
  parameter int DW          = 32
) (
  input  logic          clock,
  input  logic          clear_n,
  input  logic          start,
  input  logic          inc_pc,
  input  logic [4:0]    opcode,
  input  logic [DW-1:0] ra_data,
  input  logic [DW-1:0] rb_data,
  input  logic [DW-1:0] alu_chigh,
  input  logic [DW-1:0] alu_clow,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [13:0]   alu_ctrl,
  output logic [DW-1:0] z_high,
  output logic [DW-1:0] z_low,
  output logic          hi_en,
  output logic          lo_en,
  output logic          rz_en,
  output logic          busy,
  output logic          done,
  output logic          illegal,
  output logic [2:0]    dbg_state
);

  // Opcode encodings
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // Bit positions in the one-hot control word
  localparam int B_ADD  = 0;
  localparam int B_SUB  = 1;
  localparam int B_MUL  = 2;
  localparam int B_DIV  = 3;
  localparam int B_AND  = 4;
  localparam int B_OR   = 5;
  localparam int B_SHR  = 6;
  localparam int B_SHRA = 7;
  localparam int B_SHL  = 8;
  localparam int B_ROR  = 9;
  localparam int B_ROL  = 10;
  localparam int B_NEG  = 11;
  localparam int B_NOT  = 12;
  localparam int B_INC  = 13;

  // Extra EXEC cycles for MUL/DIV, held in a 4-bit down-counter
  localparam logic [3:0] MD_WAIT = 4'(MULDIV_WAIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_Y = 3'd1,
    S_EXEC   = 3'd2,
    S_WRITE  = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [4:0]       r_opcode;
  logic             r_inc;
  logic [DW-1:0]    r_ra;
  logic [DW-1:0]    r_y;
  logic [DW-1:0]    r_b;
  logic [2*DW-1:0]  r_z;
  logic [3:0]       r_cnt;

  logic             w_take_start;
  logic             w_take_inc;
  logic             w_in_legal;
  logic             w_is_muldiv;
  logic             w_exec_last;
  logic [13:0]      w_ctrl_dec;

  // Legality of an incoming opcode (only listed encodings are accepted)
  function automatic logic op_legal(input logic [4:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // One-hot control word for the captured operation
  function automatic logic [13:0] op_decode(input logic [4:0] op, input logic inc);
    logic [13:0] c;
    c = '0;
    if (inc) begin
      c[B_INC] = 1'b1;
    end else begin
      case (op)
        OP_ADD:  c[B_ADD]  = 1'b1;
        OP_SUB:  c[B_SUB]  = 1'b1;
        OP_MUL:  c[B_MUL]  = 1'b1;
        OP_DIV:  c[B_DIV]  = 1'b1;
        OP_AND:  c[B_AND]  = 1'b1;
        OP_OR:   c[B_OR]   = 1'b1;
        OP_SHR:  c[B_SHR]  = 1'b1;
        OP_SHRA: c[B_SHRA] = 1'b1;
        OP_SHL:  c[B_SHL]  = 1'b1;
        OP_ROR:  c[B_ROR]  = 1'b1;
        OP_ROL:  c[B_ROL]  = 1'b1;
        OP_NEG:  c[B_NEG]  = 1'b1;
        OP_NOT:  c[B_NOT]  = 1'b1;
        default: c         = '0;
      endcase
    end
    return c;
  endfunction

  assign w_take_start = (r_state == S_IDLE) && start;
  assign w_take_inc   = (r_state == S_IDLE) && !start && inc_pc;
  assign w_in_legal   = op_legal(opcode);
  assign w_is_muldiv  = !r_inc && ((r_opcode == OP_MUL) || (r_opcode == OP_DIV));
  assign w_exec_last  = (r_state == S_EXEC) && (r_cnt == 4'd0);
  assign w_ctrl_dec   = op_decode(r_opcode, r_inc);

  // FSM state register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and phase outputs
  always_comb begin
    w_next   = r_state;
    alu_ctrl = '0;
    done     = 1'b0;
    illegal  = 1'b0;
    hi_en    = 1'b0;
    lo_en    = 1'b0;
    rz_en    = 1'b0;
    busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_take_start)     w_next = w_in_legal ? S_LOAD_Y : S_ERR;
        else if (w_take_inc)  w_next = S_LOAD_Y;
      end
      S_LOAD_Y: w_next = S_EXEC;
      S_EXEC: begin
        alu_ctrl = w_ctrl_dec;
        if (r_cnt == 4'd0) w_next = S_WRITE;
      end
      S_WRITE: begin
        done = 1'b1;
        if (w_is_muldiv) begin
          hi_en = 1'b1;
          lo_en = 1'b1;
        end else begin
          rz_en = 1'b1;
        end
        w_next = S_IDLE;
      end
      S_ERR: begin
        done    = 1'b1;
        illegal = 1'b1;
        w_next  = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // Capture request, operands and opcode on accept (inc_pc loads Y with 0)
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_opcode <= '0;
      r_inc    <= 1'b0;
      r_ra     <= '0;
      r_b      <= '0;
    end else if (w_take_start) begin
      r_opcode <= opcode;
      r_inc    <= 1'b0;
      r_ra     <= ra_data;
      r_b      <= rb_data;
    end else if (w_take_inc) begin
      r_opcode <= '0;
      r_inc    <= 1'b1;
      r_ra     <= '0;
      r_b      <= rb_data;
    end
  end

  // Y load and EXEC cycle counter
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_y   <= '0;
      r_cnt <= '0;
    end else if (r_state == S_LOAD_Y) begin
      r_y   <= r_ra;
      r_cnt <= w_is_muldiv ? MD_WAIT : 4'd0;
    end else if ((r_state == S_EXEC) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Z capture on the final EXEC cycle; held until the next capture
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)         r_z <= '0;
    else if (w_exec_last) r_z <= {alu_chigh, alu_clow};
  end

  assign alu_a     = r_y;
  assign z_high    = r_z[2*DW-1:DW];
  assign z_low     = r_z[DW-1:0];
  assign dbg_state = r_state;

`ifdef ALU_SEQ_SHAMT_MASK_EN
  logic w_is_shift;
  assign w_is_shift = !r_inc && ((r_opcode == OP_SHR) || (r_opcode == OP_SHRA) ||
                                 (r_opcode == OP_SHL) || (r_opcode == OP_ROR)  ||
                                 (r_opcode == OP_ROL));
  // Shift amount only needs five bits; upper B bits are zeroed for shifts
  assign alu_b = w_is_shift ? {{(DW-5){1'b0}}, r_b[4:0]} : r_b;
`else
  assign alu_b = r_b;
`endif

endmodule
